// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues one sequential I-cache read at a time and
// buffers {pc, word} pairs for the IR. A redirect flushes the queue and restarts fetch.
module instr_prefetch_queue #(
   parameter int          DEPTH      = 4,
   parameter int          ADDR_W     = 16,
   parameter int          DATA_W     = 16,
   parameter logic [3:0]  OPCODE_NOP = 4'h0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     redirect,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic                     i_readM,
   output logic [ADDR_W-1:0]        i_address,
   input  logic                     i_inputReady,
   input  logic [DATA_W-1:0]        i_data,
   input  logic                     take,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_instr,
   output logic [ADDR_W-1:0]        out_pc,
   output logic [1:0]               o_dbg_state,
   output logic [$clog2(DEPTH):0]   o_dbg_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [DATA_W-1:0] NOP_WORD = {OPCODE_NOP, {(DATA_W-4){1'b0}}};

   // Handshakes: a cache request holds i_readM/i_address until the single-cycle
   // i_inputReady pulse completes it; the head is consumed when out_valid & take.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_readM;
   logic [ADDR_W-1:0]   r_address;
   logic [ADDR_W-1:0]   r_fetch_pc;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [DATA_W-1:0]   r_mem_data [DEPTH];
   logic [ADDR_W-1:0]   r_mem_pc   [DEPTH];

   logic                w_readM_nxt;
   logic                w_load_addr;
   logic                w_push;
   logic                w_pop;
   logic                w_out_valid;

   assign w_out_valid = (r_count != '0);
   assign w_pop       = take & w_out_valid & ~redirect;

   always_comb begin
      w_state_nxt = r_state;
      w_readM_nxt = r_readM;
      w_load_addr = 1'b0;
      w_push      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Only one request is ever outstanding, so a free slot now means the push cannot overflow.
            if (!redirect && (r_count < CNT_W'(DEPTH))) begin
               w_state_nxt = ST_REQ;
               w_readM_nxt = 1'b1;
               w_load_addr = 1'b1;
            end
         end
         ST_REQ: begin
            if (i_inputReady) begin
               w_push      = ~redirect;
               w_readM_nxt = 1'b0;
               w_state_nxt = ST_IDLE;
            end else if (redirect) begin
               w_state_nxt = ST_DROP;
            end
         end
         ST_DROP: begin
            if (i_inputReady) begin
               w_readM_nxt = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_readM_nxt = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_readM    <= 1'b0;
         r_address  <= '0;
         r_fetch_pc <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_readM <= w_readM_nxt;
         if (w_load_addr) begin
            r_address <= r_fetch_pc;
         end
         if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
         end else begin
            if (w_push) begin
               r_fetch_pc <= r_fetch_pc + 1'b1;
               r_wr_ptr   <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= i_data;
         r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
      end
   end

   assign i_readM     = r_readM;
   assign i_address   = r_address;
   assign out_valid   = w_out_valid;
   assign out_instr   = w_out_valid ? r_mem_data[r_rd_ptr] : NOP_WORD;
   assign out_pc      = w_out_valid ? r_mem_pc[r_rd_ptr] : '0;
   assign o_dbg_state = r_state;
   assign o_dbg_count = r_count;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: the bench plays the I-cache, keeps a
// model queue of {pc, word} and compares the head whenever the IR side pops.
module tb_instr_prefetch_queue;

   localparam logic [1:0]  ST_IDLE  = 2'd0;
   localparam logic [1:0]  ST_DROP  = 2'd2;
   localparam logic [15:0] NOP_WORD = 16'h0000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        i_readM;
   logic [15:0] i_address;
   logic        i_inputReady;
   logic [15:0] i_data;
   logic        take;
   logic        out_valid;
   logic [15:0] out_instr;
   logic [15:0] out_pc;
   logic [1:0]  dbg_state;
   logic [2:0]  dbg_count;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [15:0] exp_fetch;

   instr_prefetch_queue dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .i_readM      (i_readM),
      .i_address    (i_address),
      .i_inputReady (i_inputReady),
      .i_data       (i_data),
      .take         (take),
      .out_valid    (out_valid),
      .out_instr    (out_instr),
      .out_pc       (out_pc),
      .o_dbg_state  (dbg_state),
      .o_dbg_count  (dbg_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_head(input string tag);
      logic [31:0] e;
      chk({tag, "_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) e = exp_q[0];
      else                   e = {16'h0000, NOP_WORD};
      chk({tag, "_pc"},    32'(out_pc),    32'(e[31:16]));
      chk({tag, "_instr"}, 32'(out_instr), 32'(e[15:0]));
      chk({tag, "_count"}, 32'(dbg_count), 32'(exp_q.size()));
   endtask

   task automatic wait_req(input string tag, input int max_wait);
      int w = 0;
      while (i_readM !== 1'b1 && w < max_wait) begin
         tick();
         w++;
      end
      chk({tag, "_req_seen"}, 32'(i_readM), 32'd1);
      chk({tag, "_req_addr"}, 32'(i_address), 32'(exp_fetch));
   endtask

   task automatic ack(input logic [15:0] d);
      i_inputReady = 1'b1;
      i_data       = d;
      tick();
      i_inputReady = 1'b0;
      i_data       = 16'(($urandom_range(0, 65535)));
   endtask

   task automatic serve(input string tag, input int lat, input int max_wait);
      logic [15:0] d;
      wait_req(tag, max_wait);
      for (int k = 0; k < lat; k++) tick();
      d = 16'($urandom_range(0, 65535));
      ack(d);
      exp_q.push_back({exp_fetch, d});
      exp_fetch = exp_fetch + 16'd1;
   endtask

   task automatic pop_check(input string tag);
      check_head(tag);
      take = 1'b1;
      tick();
      take = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
   endtask

   task automatic redir(input logic [15:0] pc, input bit with_ack, input bit with_take);
      redirect     = 1'b1;
      redirect_pc  = pc;
      i_inputReady = with_ack;
      i_data       = 16'hDEAD;
      take         = with_take;
      tick();
      redirect     = 1'b0;
      i_inputReady = 1'b0;
      take         = 1'b0;
      exp_q.delete();
      exp_fetch = pc;
   endtask

   initial begin
      logic [15:0] d;
      int          w;
      reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
      i_inputReady = 1'b0; i_data = '0; take = 1'b0;
      exp_fetch = 16'h0000;
      repeat (3) tick();
      chk("rst_readM", 32'(i_readM), 32'd0);
      chk("rst_addr",  32'(i_address), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check_head("rst");
      reset_n = 1'b1;

      // fill queue with one-cycle cache latency, no consumer
      for (int i = 0; i < 4; i++) serve("fill", 1, 5);
      check_head("full");
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("full_no_req", 32'(i_readM), 32'd0);
      end

      // one pop frees a slot, refetch of address 4 within two cycles
      pop_check("pop1");
      check_head("after_pop1");
      serve("refill", 1, 2);
      check_head("refilled");

      // redirect while a request is pending: DROP until the late ack
      pop_check("pop2");
      wait_req("pend", 3);
      redir(16'h0040, 1'b0, 1'b0);
      chk("drop_state", 32'(dbg_state), 32'(ST_DROP));
      chk("drop_readM", 32'(i_readM), 32'd1);
      chk("drop_addr",  32'(i_address), 32'h5);
      check_head("drop");
      tick(); tick();
      ack(16'hBEEF);
      chk("drop_done_state", 32'(dbg_state), 32'(ST_IDLE));
      check_head("drop_done");
      serve("after_drop", 1, 4);
      check_head("after_drop_q");

      // redirect and ack in the same cycle: word discarded
      wait_req("pend2", 3);
      redir(16'h0100, 1'b1, 1'b0);
      chk("redir_ack_state", 32'(dbg_state), 32'(ST_IDLE));
      chk("redir_ack_readM", 32'(i_readM), 32'd0);
      check_head("redir_ack");
      serve("after_redir_ack", 2, 4);
      check_head("q_0100");

      // redirect and take in the same cycle, then take while empty
      redir(16'h0200, 1'b0, 1'b1);
      check_head("redir_take");
      take = 1'b1;
      tick();
      take = 1'b0;
      check_head("take_empty");

      // push and pop in the same cycle at count 2
      serve("pp_a", 1, 4);
      serve("pp_b", 1, 4);
      check_head("pp_two");
      wait_req("pp_c", 4);
      tick();
      check_head("pp_before");
      d = 16'($urandom_range(0, 65535));
      i_inputReady = 1'b1; i_data = d; take = 1'b1;
      void'(exp_q.pop_front());
      tick();
      i_inputReady = 1'b0; take = 1'b0;
      exp_q.push_back({exp_fetch, d});
      exp_fetch = exp_fetch + 16'd1;
      check_head("pp_after");
      pop_check("pp_pop1");
      pop_check("pp_pop2");

      // fetch address wraps from 0xFFFF to 0x0000
      w = 0;
      while (i_readM !== 1'b1 && w < 4) begin tick(); w++; end
      redir(16'hFFFF, 1'b0, 1'b0);
      chk("wrap_drop_state", 32'(dbg_state), 32'(ST_DROP));
      ack(16'h1234);
      serve("wrap_a", 1, 4);
      serve("wrap_b", 1, 4);
      check_head("wrap_q");
      wait_req("wrap_c", 4);

      // async reset mid-request, then a late ack that must be ignored
      reset_n = 1'b0;
      #1;
      chk("arst_readM", 32'(i_readM), 32'd0);
      chk("arst_state", 32'(dbg_state), 32'(ST_IDLE));
      exp_q.delete();
      exp_fetch = 16'h0000;
      check_head("arst");
      tick();
      reset_n = 1'b1;
      ack(16'h7777);
      check_head("late_ack");
      chk("late_ack_readM", 32'(i_readM), 32'd1);
      chk("late_ack_addr",  32'(i_address), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
